// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the decode stage and the multiply/divide unit.
// The master drives the decoded instruction fields; the slave returns HI/LO and status.
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             read_hilo;
  logic             mt_en;
  logic             mt_sel;
  logic [WIDTH-1:0] mt_val;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             stall;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, op, rs_val, rt_val, read_hilo, mt_en, mt_sel, mt_val,
    input  hi, lo, busy, stall, done, div_by_zero
  );

  modport slave (
    input  start, op, rs_val, rt_val, read_hilo, mt_en, mt_sel, mt_val,
    output hi, lo, busy, stall, done, div_by_zero
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO: one shared adder step per cycle,
// WIDTH iterations on magnitudes, then a sign-fixup cycle before HI/LO are written.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input logic                clk,
  input logic                reset_n,
  muldiv_sequencer_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, SIGN} state_t;

  state_t             state;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   rs_orig;
  logic               is_div;
  logic               neg_rs;
  logic               neg_rt;
  logic               div_zero;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               busy_r;
  logic               done_r;
  logic               dz_r;

  logic [WIDTH-1:0]   abs_rs;
  logic [WIDTH-1:0]   abs_rt;
  logic [WIDTH:0]     add_a;
  logic [WIDTH:0]     add_b;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] mul_res;
  logic [WIDTH-1:0]   quo_res;
  logic [WIDTH-1:0]   rem_res;
  logic [WIDTH-1:0]   hi_res;
  logic [WIDTH-1:0]   lo_res;

  assign abs_rs = (bus.op[0] && bus.rs_val[WIDTH-1]) ? -bus.rs_val : bus.rs_val;
  assign abs_rt = (bus.op[0] && bus.rt_val[WIDTH-1]) ? -bus.rt_val : bus.rt_val;

  // One adder serves both: add multiplicand into the upper half, or trial-subtract
  // the divisor from the shifted partial remainder (sum MSB set means it went negative).
  always_comb begin
    add_a    = '0;
    add_b    = '0;
    acc_next = acc;
    if (is_div) begin
      add_a = acc[2*WIDTH-1:WIDTH-1];
      add_b = ~{1'b0, opnd};
    end else begin
      add_a = {1'b0, acc[2*WIDTH-1:WIDTH]};
      add_b = acc[0] ? {1'b0, opnd} : '0;
    end
    sum = add_a + add_b + {{WIDTH{1'b0}}, is_div};
    if (is_div) begin
      if (sum[WIDTH])
        acc_next = {acc[2*WIDTH-2:0], 1'b0};
      else
        acc_next = {sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end
  end

  always_comb begin
    mul_res = (neg_rs ^ neg_rt) ? -acc : acc;
    quo_res = (neg_rs ^ neg_rt) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_res = neg_rs ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    hi_res  = mul_res[2*WIDTH-1:WIDTH];
    lo_res  = mul_res[WIDTH-1:0];
    if (is_div) begin
      if (div_zero) begin
        hi_res = rs_orig;
        lo_res = '1;
      end else begin
        hi_res = rem_res;
        lo_res = quo_res;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      count    <= '0;
      acc      <= '0;
      opnd     <= '0;
      rs_orig  <= '0;
      is_div   <= 1'b0;
      neg_rs   <= 1'b0;
      neg_rt   <= 1'b0;
      div_zero <= 1'b0;
      hi_r     <= '0;
      lo_r     <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      dz_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            is_div   <= bus.op[1];
            neg_rs   <= bus.op[0] & bus.rs_val[WIDTH-1];
            neg_rt   <= bus.op[0] & bus.rt_val[WIDTH-1];
            rs_orig  <= bus.rs_val;
            div_zero <= bus.op[1] && (bus.rt_val == '0);
            opnd     <= bus.op[1] ? abs_rt : abs_rs;
            acc      <= {{WIDTH{1'b0}}, (bus.op[1] ? abs_rs : abs_rt)};
            count    <= '0;
            dz_r     <= 1'b0;
            busy_r   <= 1'b1;
            state    <= RUN;
          end else if (bus.mt_en) begin
            if (bus.mt_sel)
              hi_r <= bus.mt_val;
            else
              lo_r <= bus.mt_val;
          end
        end
        RUN: begin
          acc   <= acc_next;
          count <= count + CW'(1);
          if (count == LAST)
            state <= SIGN;
        end
        SIGN: begin
          hi_r   <= hi_res;
          lo_r   <= lo_res;
          dz_r   <= div_zero;
          done_r <= 1'b1;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.hi          = hi_r;
  assign bus.lo          = lo_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.div_by_zero = dz_r;
  assign bus.stall       = busy_r & (bus.start | bus.read_hilo | bus.mt_en);
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed vector table, hazard/reset
// sequences, and random operations checked against a plain-arithmetic model.
module tb_muldiv_sequencer;
  logic clk;
  logic reset_n;
  int   pass_count;
  int   total_count;

  muldiv_sequencer_if #(.WIDTH(32)) bus ();

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  vec_t vecs[11];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total_count++;
    if (actual === expected)
      pass_count++;
    else
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Issues one operation from an IDLE cycle and waits (bounded) for done.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                               output int lat);
    logic [31:0] hi_before;
    hi_before    = bus.hi;
    bus.start    = 1'b1;
    bus.op       = o;
    bus.rs_val   = a;
    bus.rt_val   = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    checkOutput("busy_after_accept", 64'(bus.busy), 64'd1);
    checkOutput("dz_cleared_on_start", 64'(bus.div_by_zero), 64'd0);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (i == 16)
        checkOutput("hi_held_during_run", 64'(bus.hi), 64'(hi_before));
      if (bus.done) begin
        lat = i;
        break;
      end
    end
  endtask

  function automatic logic [64:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    case (o)
      2'd0: begin
        p = {32'd0, a} * {32'd0, b};
        return {1'b0, p};
      end
      2'd1: begin
        p = sa * sb;
        return {1'b0, p};
      end
      2'd2: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        return {1'b0, a % b, a / b};
      end
      default: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
      end
    endcase
  endfunction

  initial begin
    int          lat;
    int          stall_cycles;
    int          done_pulses;
    logic [64:0] expv;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    vecs[0]  = '{"multu_max",     2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1]  = '{"mult_neg3x7",   2'd1, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[2]  = '{"div_neg7by2",   2'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3]  = '{"divu_7by0",     2'd2, 32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF, 1'b1};
    vecs[4]  = '{"multu_6x7",     2'd0, 32'd6,         32'd7,         32'd0,         32'd42,        1'b0};
    vecs[5]  = '{"div_min_by_m1", 2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0};
    vecs[6]  = '{"div_7by_neg2",  2'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
    vecs[7]  = '{"div_neg5by0",   2'd3, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1};
    vecs[8]  = '{"mult_min_sq",   2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         1'b0};
    vecs[9]  = '{"divu_100by7",   2'd2, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
    vecs[10] = '{"mult_m1xm1",    2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd1,         1'b0};

    pass_count    = 0;
    total_count   = 0;
    reset_n       = 1'b0;
    bus.start     = 1'b0;
    bus.op        = 2'd0;
    bus.rs_val    = '0;
    bus.rt_val    = '0;
    bus.read_hilo = 1'b0;
    bus.mt_en     = 1'b0;
    bus.mt_sel    = 1'b0;
    bus.mt_val    = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_hi", 64'(bus.hi), 64'd0);
    checkOutput("reset_lo", 64'(bus.lo), 64'd0);
    checkOutput("reset_busy", 64'(bus.busy), 64'd0);
    checkOutput("reset_done", 64'(bus.done), 64'd0);
    checkOutput("reset_dz", 64'(bus.div_by_zero), 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].op, vecs[k].rs, vecs[k].rt, lat);
      checkOutput({vecs[k].name, "_latency"}, 64'(lat), 64'd33);
      checkOutput({vecs[k].name, "_hi"}, 64'(bus.hi), 64'(vecs[k].hi));
      checkOutput({vecs[k].name, "_lo"}, 64'(bus.lo), 64'(vecs[k].lo));
      checkOutput({vecs[k].name, "_dz"}, 64'(bus.div_by_zero), 64'(vecs[k].dz));
      @(posedge clk); #1;
      checkOutput({vecs[k].name, "_done_clears"}, 64'(bus.done), 64'd0);
    end

    // MFHI/MFLO arriving mid-multiply must stall until the result lands.
    bus.start  = 1'b1;
    bus.op     = 2'd0;
    bus.rs_val = 32'd6;
    bus.rt_val = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    bus.read_hilo = 1'b1;
    #1;
    stall_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) break;
      if (bus.stall) stall_cycles++;
      @(posedge clk); #1;
    end
    checkOutput("readhilo_stall_cycles", 64'(stall_cycles), 64'd29);
    checkOutput("readhilo_unstalled", 64'(bus.stall), 64'd0);
    checkOutput("readhilo_lo", 64'(bus.lo), 64'd42);
    checkOutput("readhilo_hi", 64'(bus.hi), 64'd0);
    bus.read_hilo = 1'b0;
    @(posedge clk); #1;

    // Back-to-back starts: second one is held by stall and accepted at E34.
    done_pulses = 0;
    bus.start  = 1'b1;
    bus.op     = 2'd0;
    bus.rs_val = 32'd2;
    bus.rt_val = 32'd3;
    @(posedge clk); #1;
    bus.op     = 2'd2;
    bus.rs_val = 32'd100;
    bus.rt_val = 32'd7;
    checkOutput("b2b_stall_while_busy", 64'(bus.stall), 64'd1);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin lat = i; done_pulses++; break; end
    end
    checkOutput("b2b_first_latency", 64'(lat), 64'd33);
    checkOutput("b2b_first_lo", 64'(bus.lo), 64'd6);
    @(posedge clk); #1;
    checkOutput("b2b_second_accepted", 64'(bus.busy), 64'd1);
    bus.start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin lat = i; done_pulses++; break; end
    end
    checkOutput("b2b_second_latency", 64'(lat), 64'd33);
    checkOutput("b2b_lo", 64'(bus.lo), 64'd14);
    checkOutput("b2b_hi", 64'(bus.hi), 64'd2);
    checkOutput("b2b_done_pulses", 64'(done_pulses), 64'd2);
    @(posedge clk); #1;

    // Reset partway through RUN discards the operation; then MTLO/MTHI in IDLE.
    bus.start  = 1'b1;
    bus.op     = 2'd0;
    bus.rs_val = 32'h0000_FFFF;
    bus.rt_val = 32'h0000_FFFF;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("midreset_busy", 64'(bus.busy), 64'd0);
    checkOutput("midreset_hi", 64'(bus.hi), 64'd0);
    checkOutput("midreset_lo", 64'(bus.lo), 64'd0);
    reset_n    = 1'b1;
    bus.mt_en  = 1'b1;
    bus.mt_sel = 1'b0;
    bus.mt_val = 32'h1234;
    #1;
    checkOutput("mtlo_no_stall", 64'(bus.stall), 64'd0);
    @(posedge clk); #1;
    checkOutput("mtlo_lo", 64'(bus.lo), 64'h1234);
    bus.mt_sel = 1'b1;
    bus.mt_val = 32'hCAFE_0001;
    @(posedge clk); #1;
    bus.mt_en = 1'b0;
    checkOutput("mthi_hi", 64'(bus.hi), 64'hCAFE_0001);
    checkOutput("mthi_lo_untouched", 64'(bus.lo), 64'h1234);

    for (int n = 0; n < 40; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      expv = ref_model(rop, ra, rb);
      applyStimulus(rop, ra, rb, lat);
      checkOutput($sformatf("rand%0d_latency", n), 64'(lat), 64'd33);
      checkOutput($sformatf("rand%0d_op%0d_hi", n, rop), 64'(bus.hi), 64'(expv[63:32]));
      checkOutput($sformatf("rand%0d_op%0d_lo", n, rop), 64'(bus.lo), 64'(expv[31:0]));
      checkOutput($sformatf("rand%0d_dz", n), 64'(bus.div_by_zero), 64'(expv[64]));
    end

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end
endmodule
